// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings and the iteration-counter width helper.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_DEFAULT = 4;

    // Counter must hold the value 2W, so one bit more than clog2(2W).
    function automatic int cnt_width(input int w);
        return $clog2(2 * w) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(W_DEFAULT);

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_restoring_divider_if #(
    parameter int W = 4
);
    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   quotient;
    logic [W-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider_div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, keep the difference only when it is non-negative.
module div_sub_step
    import seq_restoring_divider_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W:0]   p_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] p_o,
    output logic         q_bit_o
);
    logic [W:0] diff;

    // The caller keeps p_i < 2*divisor, so the W+1-bit difference is either
    // below 2^W (subtraction fits) or wraps with its top bit set (borrow).
    always_comb begin
        diff    = p_i - {1'b0, divisor_i};
        q_bit_o = ~diff[W];
        p_o     = q_bit_o ? diff[W-1:0] : p_i[W-1:0];
    end
endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, with start/busy/done handshake and divide-by-zero flag.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CNT_W = cnt_width(W);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   d_q, d_d;
    logic [W-1:0]     p_q, p_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [2*W-1:0]   quot_q, quot_d;
    logic [W-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [W:0]       step_p;
    logic [W-1:0]     step_p_out;
    logic             step_q_bit;

    // Bring the next dividend bit into the partial remainder.
    assign step_p = {p_q, d_q[2*W-1]};

    div_sub_step #(.W(W)) u_step (
        .p_i       (step_p),
        .divisor_i (dvs_q),
        .p_o       (step_p_out),
        .q_bit_o   (step_q_bit)
    );

    // State, datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            p_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            p_q     <= p_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state, iteration and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        p_d     = p_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    d_d   = bus.dividend;
                    dvs_d = bus.divisor;
                    p_d   = '0;
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        // No iterations needed: publish the fixed result now.
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend[W-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        dbz_d   = 1'b0;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                d_d   = {d_q[2*W-2:0], step_q_bit};
                p_d   = step_p_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(2 * W - 1)) begin
                    state_d = DONE;
                    quot_d  = {d_q[2*W-2:0], step_q_bit};
                    rem_d   = step_p_out;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
